// File: rtl/sdram_arbit_if.sv
// rtl/sdram_arbit_if.sv - sequencer-side and SDRAM-side signal bundle of the SDRAM command arbiter
//
// Purpose: groups every arbiter signal except clk/rst.
//   master modport: the environment side (sequencers and SDRAM pins)
//   slave  modport: the arbiter side
// Signal summary:
//   init_end, init_cmd[3:0], init_addr[11:0]           init sequencer
//   ref_req, flag_ref_end, aref_cmd, aref_addr          auto-refresh sequencer
//   wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
//   wr_data[15:0]                                       write sequencer
//   rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank       read sequencer
//   ref_en, wr_en, rd_en                                grants
//   sdram_cke, sdram_cmd, sdram_addr, sdram_bank,
//   sdram_dq_oe, sdram_dq_out                           SDRAM bus
//   err_timeout                                         sticky watchdog error
interface sdram_arbit_if;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic        ref_req;
  logic        flag_ref_end;
  logic [3:0]  aref_cmd;
  logic [11:0] aref_addr;
  logic        wr_req;
  logic        flag_wr_end;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_bank;
  logic [15:0] wr_data;
  logic        rd_req;
  logic        flag_rd_end;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank;
  logic        ref_en;
  logic        wr_en;
  logic        rd_en;
  logic        sdram_cke;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic        sdram_dq_oe;
  logic [15:0] sdram_dq_out;
  logic        err_timeout;

  modport master (
    output init_end, init_cmd, init_addr,
    output ref_req, flag_ref_end, aref_cmd, aref_addr,
    output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
    output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
    input  ref_en, wr_en, rd_en,
    input  sdram_cke, sdram_cmd, sdram_addr, sdram_bank, sdram_dq_oe, sdram_dq_out,
    input  err_timeout
  );

  modport slave (
    input  init_end, init_cmd, init_addr,
    input  ref_req, flag_ref_end, aref_cmd, aref_addr,
    input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank, wr_data,
    input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
    output ref_en, wr_en, rd_en,
    output sdram_cke, sdram_cmd, sdram_addr, sdram_bank, sdram_dq_oe, sdram_dq_out,
    output err_timeout
  );
endinterface

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - fixed-priority SDRAM command arbiter (refresh > write > read) with watchdog
//
// Purpose: grants the SDRAM bus to one sequencer at a time and muxes the
// granted sequencer's cmd/addr/bank/data onto the pins. A watchdog forces
// the bus back to arbitration if a grant is held TIMEOUT+1 cycles without
// an end flag, and latches err_timeout.
// Ports:
//   TIMEOUT  parameter, 1..1023, watchdog limit
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   bus      sdram_arbit_if.slave, all sequencer and SDRAM signals
module sdram_arbit #(
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  sdram_arbit_if.slave  bus
);

  typedef enum logic [4:0] {
    ST_INIT  = 5'b00001,
    ST_ARBIT = 5'b00010,
    ST_AREF  = 5'b00100,
    ST_WRITE = 5'b01000,
    ST_READ  = 5'b10000
  } state_t;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

  state_t      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        grant, end_flag, expired;

  always_comb begin
    grant    = (state_q == ST_AREF) || (state_q == ST_WRITE) || (state_q == ST_READ);
    // Only the end flag belonging to the current owner counts.
    end_flag = ((state_q == ST_AREF)  && bus.flag_ref_end) ||
               ((state_q == ST_WRITE) && bus.flag_wr_end)  ||
               ((state_q == ST_READ)  && bus.flag_rd_end);
    // A coincident end flag wins over expiry: treated as normal completion.
    expired  = grant && !end_flag && (cnt_q == TIMEOUT_C);

    state_d = state_q;
    err_d   = err_q | expired;

    case (state_q)
      ST_INIT: begin
        if (bus.init_end) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (bus.ref_req)     state_d = ST_AREF;
        else if (bus.wr_req) state_d = ST_WRITE;
        else if (bus.rd_req) state_d = ST_READ;
      end
      ST_AREF, ST_WRITE, ST_READ: begin
        if (end_flag || expired) state_d = ST_ARBIT;
      end
      default: state_d = ST_INIT;
    endcase

    // Counts cycles spent in the current grant; zero whenever not granted.
    cnt_d = (grant && (state_d == state_q)) ? cnt_q + 10'd1 : 10'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= 10'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  logic [3:0]  cmd_mux;
  logic [11:0] addr_mux;
  logic [1:0]  bank_mux;

  always_comb begin
    cmd_mux  = CMD_NOP;
    addr_mux = 12'd0;
    bank_mux = 2'd0;
    case (state_q)
      ST_INIT: begin
        cmd_mux  = bus.init_cmd;
        addr_mux = bus.init_addr;
      end
      ST_AREF: begin
        cmd_mux  = bus.aref_cmd;
        addr_mux = bus.aref_addr;
      end
      ST_WRITE: begin
        cmd_mux  = bus.wr_cmd;
        addr_mux = bus.wr_addr;
        bank_mux = bus.wr_bank;
      end
      ST_READ: begin
        cmd_mux  = bus.rd_cmd;
        addr_mux = bus.rd_addr;
        bank_mux = bus.rd_bank;
      end
      default: ;
    endcase
    // Keep the pins quiet while reset is asserted, before state settles.
    if (rst) begin
      cmd_mux  = CMD_NOP;
      addr_mux = 12'd0;
      bank_mux = 2'd0;
    end
  end

  assign bus.ref_en       = (state_q == ST_AREF);
  assign bus.wr_en        = (state_q == ST_WRITE);
  assign bus.rd_en        = (state_q == ST_READ);
  assign bus.sdram_cke    = 1'b1;
  assign bus.sdram_cmd    = cmd_mux;
  assign bus.sdram_addr   = addr_mux;
  assign bus.sdram_bank   = bank_mux;
  assign bus.sdram_dq_oe  = (state_q == ST_WRITE) && !rst;
  assign bus.sdram_dq_out = (state_q == ST_WRITE) ? bus.wr_data : 16'd0;
  assign bus.err_timeout  = err_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - randomized self-checking bench for sdram_arbit against a cycle-level owner model
module tb_sdram_arbit;

  localparam int TMO    = 8;
  localparam int NCYC   = 3000;

  localparam int OWN_INIT = 0;
  localparam int OWN_IDLE = 1;
  localparam int OWN_REF  = 2;
  localparam int OWN_WR   = 3;
  localparam int OWN_RD   = 4;

  logic clk = 1'b0;
  logic rst;

  sdram_arbit_if bus ();

  sdram_arbit #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, when the ownership began, sticky error.
  int   owner;
  int   grant_start;
  logic m_err;
  int   init_on_cyc;
  int   n_timeouts;
  int   n_grants;

  logic [3:0]  e_cmd;
  logic [11:0] e_addr;
  logic [1:0]  e_bank;
  logic        own_end;

  initial begin
    owner       = OWN_INIT;
    grant_start = 0;
    m_err       = 1'b0;
    init_on_cyc = 5;
    n_timeouts  = 0;
    n_grants    = 0;

    rst = 1'b1;
    bus.init_end = 1'b0; bus.init_cmd = '0; bus.init_addr = '0;
    bus.ref_req = 1'b0; bus.flag_ref_end = 1'b0; bus.aref_cmd = '0; bus.aref_addr = '0;
    bus.wr_req = 1'b0; bus.flag_wr_end = 1'b0; bus.wr_cmd = '0; bus.wr_addr = '0;
    bus.wr_bank = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.flag_rd_end = 1'b0; bus.rd_cmd = '0; bus.rd_addr = '0; bus.rd_bank = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // Reset for the first three cycles, then occasional mid-run pulses.
      rst = (cyc < 3) || ($urandom_range(0, 249) == 0);
      if (rst && cyc >= 3) init_on_cyc = cyc + int'($urandom_range(1, 4));
      bus.init_end     = (cyc >= init_on_cyc);
      bus.init_cmd     = 4'($urandom);
      bus.init_addr    = 12'($urandom);
      bus.ref_req      = ($urandom_range(0, 5) == 0);
      bus.wr_req       = $urandom_range(0, 1) == 1;
      bus.rd_req       = $urandom_range(0, 1) == 1;
      bus.flag_ref_end = ($urandom_range(0, 9) == 0);
      bus.flag_wr_end  = ($urandom_range(0, 9) == 0);
      bus.flag_rd_end  = ($urandom_range(0, 9) == 0);
      bus.aref_cmd     = 4'($urandom);
      bus.aref_addr    = 12'($urandom);
      bus.wr_cmd       = 4'($urandom);
      bus.wr_addr      = 12'($urandom);
      bus.wr_bank      = 2'($urandom);
      bus.wr_data      = 16'($urandom);
      bus.rd_cmd       = 4'($urandom);
      bus.rd_addr      = 12'($urandom);
      bus.rd_bank      = 2'($urandom);
      #1;

      // Expected pin values for the current owner and current inputs.
      e_cmd = 4'b0111; e_addr = 12'd0; e_bank = 2'd0;
      if (!rst) begin
        case (owner)
          OWN_INIT: begin e_cmd = bus.init_cmd; e_addr = bus.init_addr; end
          OWN_REF:  begin e_cmd = bus.aref_cmd; e_addr = bus.aref_addr; end
          OWN_WR:   begin e_cmd = bus.wr_cmd; e_addr = bus.wr_addr; e_bank = bus.wr_bank; end
          OWN_RD:   begin e_cmd = bus.rd_cmd; e_addr = bus.rd_addr; e_bank = bus.rd_bank; end
          default:  ;
        endcase
      end
      check("grants", {29'd0, bus.ref_en, bus.wr_en, bus.rd_en},
            {29'd0, owner == OWN_REF, owner == OWN_WR, owner == OWN_RD});
      check("cmd",    {28'd0, bus.sdram_cmd},  {28'd0, e_cmd});
      check("addr",   {20'd0, bus.sdram_addr}, {20'd0, e_addr});
      check("bank",   {30'd0, bus.sdram_bank}, {30'd0, e_bank});
      check("dq_oe",  {31'd0, bus.sdram_dq_oe}, {31'd0, !rst && owner == OWN_WR});
      check("dq_out", {16'd0, bus.sdram_dq_out}, {16'd0, (owner == OWN_WR) ? bus.wr_data : 16'd0});
      check("err",    {31'd0, bus.err_timeout}, {31'd0, m_err});
      check("cke",    {31'd0, bus.sdram_cke}, 32'd1);

      // Advance the model across the coming rising edge.
      if (rst) begin
        owner = OWN_INIT;
        m_err = 1'b0;
      end else if (owner == OWN_INIT) begin
        if (bus.init_end) owner = OWN_IDLE;
      end else if (owner == OWN_IDLE) begin
        grant_start = cyc + 1;
        if (bus.ref_req)     owner = OWN_REF;
        else if (bus.wr_req) owner = OWN_WR;
        else if (bus.rd_req) owner = OWN_RD;
        if (owner != OWN_IDLE) n_grants++;
      end else begin
        own_end = (owner == OWN_REF && bus.flag_ref_end) ||
                  (owner == OWN_WR  && bus.flag_wr_end)  ||
                  (owner == OWN_RD  && bus.flag_rd_end);
        if (own_end) begin
          owner = OWN_IDLE;
        end else if (cyc - grant_start >= TMO) begin
          // Held for TMO+1 cycles without completion: forced release.
          owner = OWN_IDLE;
          m_err = 1'b1;
          n_timeouts++;
        end
      end
    end

    check("grants_seen",   {31'd0, n_grants > 20},  32'd1);
    check("timeouts_seen", {31'd0, n_timeouts > 0}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
